// File: rtl/spi_tx_scheduler_if.sv
// Handshake bundle between a word producer, the scheduler and the downstream SPI top.
// "slave" is the scheduler's view; "master" is the view of the environment around it.
interface spi_tx_scheduler_if #(
  parameter int WIDTH = 12
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             new_data;
  logic [WIDTH-1:0] din;
  logic             done;

  modport master (
    output wr_valid, wr_data, done,
    input  wr_ready, new_data, din
  );

  modport slave (
    input  wr_valid, wr_data, done,
    output wr_ready, new_data, din
  );
endinterface

// File: rtl/spi_tx_scheduler.sv
// Buffers words in a small FIFO and launches them one frame at a time into an SPI top,
// waiting for done (or a timeout) and then a fixed idle gap before the next launch.
module spi_tx_scheduler #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 12,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  spi_tx_scheduler_if.slave      bus,
  input  logic                   err_clear,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            sent_count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic [WIDTH-1:0] din_reg, din_next;
  logic             new_data_reg, new_data_next;
  logic             wr_ready_reg, wr_ready_next;
  logic             busy_reg, busy_next;
  logic             err_reg, err_next;
  logic [15:0]      sent_reg, sent_next;

  logic push, pop, done_hit, timeout_hit;

  // wr_ready is the registered not-full flag, so a full FIFO refuses even when popping.
  assign push        = bus.wr_valid && wr_ready_reg;
  assign pop         = (state_reg == IDLE) && (level_reg != '0);
  assign done_hit    = (state_reg == WAIT_DONE) && bus.done;
  assign timeout_hit = (state_reg == WAIT_DONE) && !bus.done &&
                       (timer_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (level_reg != '0) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_DONE;
      WAIT_DONE: if (done_hit || timeout_hit) state_next = GAP;
      GAP:       if (timer_reg == TW'(GAP_CYCLES - 1)) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    level_next  = level_reg + LW'(push) - LW'(pop);

    // One timer serves both the done wait and the gap; it restarts on every state change.
    timer_next = timer_reg + TW'(1);
    if (state_next != state_reg || state_reg == IDLE) begin
      timer_next = '0;
    end

    din_next = din_reg;
    if (pop) begin
      din_next = mem[rd_ptr_reg];
    end else if (state_reg == WAIT_DONE && state_next == GAP) begin
      din_next = '0;
    end

    new_data_next = (state_next == LAUNCH);
    wr_ready_next = (level_next != LW'(DEPTH));
    busy_next     = (state_next != IDLE) || (level_next != '0);
    sent_next     = sent_reg + 16'(done_hit);

    err_next = err_reg;
    if (timeout_hit) begin
      err_next = 1'b1;
    end else if (err_clear) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      timer_reg    <= '0;
      din_reg      <= '0;
      new_data_reg <= 1'b0;
      wr_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      sent_reg     <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      timer_reg    <= timer_next;
      din_reg      <= din_next;
      new_data_reg <= new_data_next;
      wr_ready_reg <= wr_ready_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
      sent_reg     <= sent_next;
    end
  end

  // Storage carries no reset; emptiness is tracked entirely by the pointers and level.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  assign bus.wr_ready = wr_ready_reg;
  assign bus.new_data = new_data_reg;
  assign bus.din      = din_reg;
  assign busy         = busy_reg;
  assign timeout_err  = err_reg;
  assign level        = level_reg;
  assign sent_count   = sent_reg;
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Self-checking bench for spi_tx_scheduler: a launch scoreboard on din ordering plus
// a frame table and hand-written timeout, fill and reset sequences.
module tb_spi_tx_scheduler;
  localparam int DEPTH   = 8;
  localparam int WIDTH   = 12;
  localparam int TIMEOUT = 1024;
  localparam int GAP     = 4;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          err_clear = 1'b0;
  logic          busy, timeout_err;
  logic [LW-1:0] level;
  logic [15:0]   sent_count;

  spi_tx_scheduler_if #(.WIDTH(WIDTH)) bus();

  spi_tx_scheduler #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .err_clear  (err_clear),
    .busy       (busy),
    .timeout_err(timeout_err),
    .level      (level),
    .sent_count (sent_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int launch_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_w;
  logic prev_nd = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               done_off;   // edge offset of done after the launch edge; 0 = never
    int               exp_sent;
    logic             exp_err;
  } frame_t;

  frame_t vec[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Words enter the expected queue as the DUT accepts them.
  always @(posedge clock) begin
    if (reset && bus.wr_valid && bus.wr_ready) exp_q.push_back(bus.wr_data);
  end

  // Every launch must present the oldest accepted word and last exactly one cycle.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.new_data) begin
        launch_cnt++;
        check("new_data_one_cycle", {31'd0, prev_nd}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL launch_without_word: din=%0h, expected no launch", bus.din);
        end else begin
          exp_w = exp_q.pop_front();
          check("din_order", 32'(bus.din), 32'(exp_w));
        end
      end
      prev_nd = bus.new_data;
    end else begin
      prev_nd = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    int tries = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    while (!bus.wr_ready && tries < 3000) begin
      @(negedge clock);
      tries++;
    end
    if (!bus.wr_ready) begin
      checks++;
      errors++;
      $display("FAIL push_accept: wr_ready=0, expected 1 for word %0h", w);
    end
    @(negedge clock);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_launch(input int bound, output int lc);
    int n = 0;
    while (!bus.new_data && n < bound) begin
      @(negedge clock);
      n++;
    end
    check("launch_seen", {31'd0, bus.new_data}, 32'd1);
    lc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_c, lc, lc2, end_c, base;
    int m_sent;
    logic m_err;
    bit valid;

    vec[0] = '{12'hA5C, 300,         1, 1'b0};  // single word, late done
    vec[1] = '{12'h5A3, TIMEOUT + 1, 2, 1'b0};  // done on the timeout edge
    vec[2] = '{12'h0F0, 2,           3, 1'b0};  // earliest possible done
    vec[3] = '{12'h7E1, 1,           3, 1'b1};  // done in LAUNCH ignored, times out

    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.done     = 1'b0;
    m_sent = 0;
    m_err  = 1'b0;

    tick(3);
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("rst_new_data", {31'd0, bus.new_data}, 32'd0);
    check("rst_din", 32'(bus.din), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_sent", 32'(sent_count), 32'd0);
    reset = 1'b1;
    tick(3);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      $display("frame %0d: word=%0h done_off=%0d", i, vec[i].word, vec[i].done_off);
      push_word(vec[i].word);
      acc_c = cyc;
      wait_launch(10, lc);
      check("launch_latency", 32'(lc - acc_c), 32'd1);
      valid = (vec[i].done_off >= 2) && (vec[i].done_off <= TIMEOUT + 1);
      end_c = valid ? lc + vec[i].done_off : lc + TIMEOUT + 1;
      if (!valid && vec[i].done_off > 0) begin
        wait_cyc(lc + vec[i].done_off - 1);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
      end
      wait_cyc(end_c - 1);
      check("pre_end_sent", 32'(sent_count), 32'(m_sent));
      check("pre_end_err", {31'd0, timeout_err}, {31'd0, m_err});
      check("pre_end_busy", {31'd0, busy}, 32'd1);
      if (valid) bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
      check("end_sent", 32'(sent_count), 32'(vec[i].exp_sent));
      check("end_err", {31'd0, timeout_err}, {31'd0, vec[i].exp_err});
      check("gap_din_cleared", 32'(bus.din), 32'd0);
      wait_cyc(end_c + GAP - 1);
      check("gap_busy", {31'd0, busy}, 32'd1);
      tick(1);
      check("after_gap_idle", {31'd0, busy}, 32'd0);
      m_sent = vec[i].exp_sent;
      m_err  = vec[i].exp_err;
    end

    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("err_clear", {31'd0, timeout_err}, 32'd0);

    // Spurious done while idle.
    base = launch_cnt;
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    tick(3);
    check("idle_done_sent", 32'(sent_count), 32'(m_sent));
    check("idle_done_busy", {31'd0, busy}, 32'd0);
    check("idle_done_launches", 32'(launch_cnt), 32'(base));

    // Timeout with a second word queued behind it; err_clear on the timeout edge loses.
    push_word(12'h3FF);
    wait_launch(10, lc);
    push_word(12'h123);
    wait_cyc(lc + TIMEOUT);
    check("timeout_not_early", {31'd0, timeout_err}, 32'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("timeout_set_wins", {31'd0, timeout_err}, 32'd1);
    check("timeout_sent", 32'(sent_count), 32'(m_sent));
    end_c = lc + TIMEOUT + 1;
    wait_cyc(end_c + GAP);
    check("relaunch_not_early", {31'd0, bus.new_data}, 32'd0);
    tick(1);
    check("relaunch_after_gap", {31'd0, bus.new_data}, 32'd1);
    lc2 = cyc;
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("err_clear_2", {31'd0, timeout_err}, 32'd0);
    $display("frame 0x123 launched at cycle %0d", lc2);

    // Fill while 0x123 waits for done, then drain with done on every frame.
    fork
      begin
        for (int k = 1; k <= 9; k++) push_word(12'(k));
      end
      begin
        int n = 0;
        int dc, l;
        while (level != LW'(DEPTH) && n < 100) begin
          tick(1);
          n++;
        end
        check("fill_level", 32'(level), 32'(DEPTH));
        check("fill_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        tick(3);
        check("full_hold_level", 32'(level), 32'(DEPTH));
        check("full_hold_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        dc = cyc;
        for (int k = 0; k < 9; k++) begin
          wait_launch(50, l);
          check("frame_spacing", 32'(l - dc), 32'(GAP + 1));
          tick(3);
          bus.done = 1'b1;
          tick(1);
          bus.done = 1'b0;
          dc = cyc;
        end
      end
    join
    m_sent = m_sent + 10;
    tick(GAP + 2);
    check("drain_sent", 32'(sent_count), 32'(m_sent));
    check("drain_level", 32'(level), 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a frame with three words queued.
    push_word(12'h456);
    push_word(12'h789);
    push_word(12'hABC);
    push_word(12'hDEF);
    tick(3);
    check("pre_reset_level", 32'(level), 32'd3);
    check("pre_reset_din", 32'(bus.din), 32'h456);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_new_data", {31'd0, bus.new_data}, 32'd0);
    check("async_rst_din", 32'(bus.din), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("async_rst_sent", 32'(sent_count), 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    tick(2);
    reset = 1'b1;
    base = launch_cnt;
    tick(20);
    check("post_rst_no_launch", 32'(launch_cnt), 32'(base));
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    push_word(12'h0AA);
    wait_launch(10, lc);
    tick(2);
    check("post_rst_launch_count", 32'(launch_cnt), 32'(base + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
